// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: IDLE/REQ/WAIT sequencer with one outstanding
// request, a one-entry skid buffer and redirect kill. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_ctrl #(
    parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic [31:0] PCNext,
    output logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        hazard_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic        InstrValidF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_wait_cycles,
    output logic [31:0] perf_kills
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_q, skid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        kill_q, kill_d;

    logic req_s, grant_s, resp_s, accept_s, consume_s;

    // Handshake qualifiers shared by next-state and output logic
    always_comb begin
        req_s     = (state_q == S_REQ) && !skid_valid_q;
        grant_s   = req_s && imem_ready;
        resp_s    = (state_q == S_WAIT) && imem_rvalid;
        accept_s  = resp_s && !kill_q && !PCSrcE;
        consume_s = valid_q && !hazard_stall;
    end

    // Next-state for the sequencer, kill flag and instruction/skid registers
    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (grant_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect with a request in flight dooms the response that is still coming
        if (resp_s) begin
            kill_d = 1'b0;
        end else if (PCSrcE && ((state_q == S_WAIT) || grant_s)) begin
            kill_d = 1'b1;
        end else begin
            kill_d = kill_q;
        end

        if (PCSrcE) begin
            valid_d      = 1'b0;
            instr_d      = INSTR_NOP;
            skid_valid_d = 1'b0;
        end else if (accept_s) begin
            if (!valid_q || !hazard_stall) begin
                instr_d = imem_rdata;
                valid_d = 1'b1;
            end else begin
                skid_d       = imem_rdata;
                skid_valid_d = 1'b1;
            end
        end else if (consume_s) begin
            if (skid_valid_q) begin
                instr_d      = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = 1'b0;
                instr_d = INSTR_NOP;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            instr_q      <= INSTR_NOP;
            valid_q      <= 1'b0;
            skid_q       <= 32'h0000_0000;
            skid_valid_q <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            kill_q       <= kill_d;
        end
    end

    // PC control: reset holds, redirect wins, accepted response advances
    always_comb begin
        if (!rst) begin
            StallF = 1'b1;
            PCNext = PCF;
        end else if (PCSrcE) begin
            StallF = 1'b0;
            PCNext = PCTargetE;
        end else if (accept_s) begin
            StallF = 1'b0;
            PCNext = PCF + 32'd4;
        end else begin
            StallF = 1'b1;
            PCNext = PCF;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = PCF;
    assign InstrF      = instr_q;
    assign InstrValidF = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_wait_q, perf_kill_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Saturating counters for stalled waits and discarded responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_wait_q <= 32'd0;
            perf_kill_q <= 32'd0;
        end else begin
            if ((state_q == S_WAIT) && !imem_rvalid) begin
                perf_wait_q <= sat_inc(perf_wait_q);
            end else begin
                perf_wait_q <= perf_wait_q;
            end
            if (resp_s && (kill_q || PCSrcE)) begin
                perf_kill_q <= sat_inc(perf_kill_q);
            end else begin
                perf_kill_q <= perf_kill_q;
            end
        end
    end

    assign perf_wait_cycles = perf_wait_q;
    assign perf_kills       = perf_kill_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-based fetch model, directed
// scenarios with literal expectations, then randomized traffic with resets.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCNext, PCTargetE, imem_addr, imem_rdata, InstrF;
    logic        StallF, PCSrcE, hazard_stall, imem_req, imem_ready, imem_rvalid, InstrValidF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_wait_cycles, perf_kills;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(.INSTR_NOP(NOP)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PCNext(PCNext), .StallF(StallF),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .hazard_stall(hazard_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrF(InstrF), .InstrValidF(InstrValidF)
`ifdef FETCH_PERF_CNT_EN
        , .perf_wait_cycles(perf_wait_cycles), .perf_kills(perf_kills)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model: queue of delivered instructions (head = InstrF, second = skid)
    logic [31:0] m_q[$];
    bit          m_idle, m_out, m_doom;
    logic [31:0] m_pw, m_pk;

    // Memory responder
    bit          mem_pend, ready_en;
    int          mem_cnt, lat;
    logic [31:0] mem_data, next_data;

    typedef struct packed {
        logic        req, stall, valid, resp, good, disc, acc, waitc;
        logic [31:0] pcnext, instr;
    } exp_t;

    function automatic exp_t calc();
        exp_t e;
        e.resp  = m_out && imem_rvalid;
        e.waitc = m_out && !imem_rvalid;
        e.good  = e.resp && !m_doom && !PCSrcE;
        e.disc  = e.resp && (m_doom || PCSrcE);
        e.req   = rst && !m_idle && !m_out && (m_q.size() < 2);
        e.acc   = e.req && imem_ready;
        e.valid = (m_q.size() > 0);
        e.instr = e.valid ? m_q[0] : NOP;
        if (!rst) begin
            e.stall = 1'b1; e.pcnext = PCF;
        end else if (PCSrcE) begin
            e.stall = 1'b0; e.pcnext = PCTargetE;
        end else if (e.good) begin
            e.stall = 1'b0; e.pcnext = PCF + 32'd4;
        end else begin
            e.stall = 1'b1; e.pcnext = PCF;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_idle = 1'b1;
        m_out  = 1'b0;
        m_doom = 1'b0;
        m_pw   = 32'd0;
        m_pk   = 32'd0;
    endtask

    // One clock: update model and memory at the edge, then drive new inputs
    task automatic step(input bit rnd);
        exp_t e;
        @(posedge clk);
        e = calc();
        if (!rst) begin
            model_reset();
        end else begin
            if (PCSrcE) begin
                m_q.delete();
            end else begin
                if (e.valid && !hazard_stall) void'(m_q.pop_front());
                if (e.good) m_q.push_back(imem_rdata);
            end
            if (e.resp) begin
                m_out = 1'b0; m_doom = 1'b0;
            end else begin
                if (PCSrcE && (e.waitc || e.acc)) m_doom = 1'b1;
                if (e.acc) m_out = 1'b1;
            end
            m_idle = 1'b0;
            if (e.waitc && m_pw != 32'hFFFF_FFFF) m_pw = m_pw + 32'd1;
            if (e.disc && m_pk != 32'hFFFF_FFFF) m_pk = m_pk + 32'd1;
            if (!e.stall) PCF = e.pcnext;
        end
        if (imem_rvalid) mem_pend = 1'b0;
        if (e.acc) begin
            mem_pend = 1'b1; mem_cnt = lat; mem_data = next_data;
        end
        #1;
        if (rnd) begin
            ready_en     = ($urandom_range(0, 3) != 0);
            hazard_stall = ($urandom_range(0, 2) == 0);
            PCSrcE       = ($urandom_range(0, 11) == 0);
            PCTargetE    = $urandom() & 32'hFFFF_FFFC;
            lat          = $urandom_range(1, 4);
            next_data    = $urandom();
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                model_reset();
                PCF = $urandom() & 32'hFFFF_FFFC;
            end
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data;
            end
        end
        imem_ready = mem_pend ? 1'b0 : ready_en;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        int n;
        rst = 1'b0;
        model_reset();
        PCF = pc0;
        PCSrcE = 1'b0;
        hazard_stall = 1'b0;
        ready_en = 1'b1;
        n = 0;
        while ((n < 2 || mem_pend) && n < 20) begin
            step(1'b0);
            n++;
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; PCF = 32'd0; PCSrcE = 1'b0; PCTargetE = 32'd0; hazard_stall = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        ready_en = 1'b1; lat = 2; next_data = 32'd0; mem_pend = 1'b0; mem_cnt = 0;
        mem_data = 32'd0;
        model_reset();
        #1 rst = 1'b0;

        // Per-cycle comparison of every output against the model
        fork
            forever begin
                exp_t ce;
                @(negedge clk);
                ce = calc();
                chk("imem_req", 32'(imem_req), 32'(ce.req));
                if (ce.req) chk("imem_addr", imem_addr, PCF);
                chk("StallF", 32'(StallF), 32'(ce.stall));
                chk("PCNext", PCNext, ce.pcnext);
                chk("InstrValidF", 32'(InstrValidF), 32'(ce.valid));
                chk("InstrF", InstrF, ce.instr);
`ifdef FETCH_PERF_CNT_EN
                chk("perf_wait_cycles", perf_wait_cycles, m_pw);
                chk("perf_kills", perf_kills, m_pk);
`endif
            end
        join_none

        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_stall", 32'(StallF), 32'd1);
        chk("rst_pcnext", PCNext, 32'd0);
        chk("rst_valid", 32'(InstrValidF), 32'd0);
        chk("rst_instr", InstrF, 32'h0000_0013);

        // Basic fetch from PC 0 with two-cycle latency
        lat = 2; next_data = 32'h0050_0093; do_reset(32'd0);
        @(negedge clk); chk("idle_req", 32'(imem_req), 32'd0);
        step(1'b0); @(negedge clk);
        chk("c1_req", 32'(imem_req), 32'd1); chk("c1_addr", imem_addr, 32'd0);
        chk("c1_stall", 32'(StallF), 32'd1);
        step(1'b0); @(negedge clk); chk("c2_stall", 32'(StallF), 32'd1);
        step(1'b0); @(negedge clk);
        chk("c3_stall", 32'(StallF), 32'd0); chk("c3_pcnext", PCNext, 32'd4);
        step(1'b0); @(negedge clk);
        chk("c4_instr", InstrF, 32'h0050_0093); chk("c4_valid", 32'(InstrValidF), 32'd1);

        // PC wrap
        lat = 1; next_data = 32'h1234_5678; do_reset(32'hFFFF_FFFC);
        step(1'b0); step(1'b0); @(negedge clk);
        chk("wrap_stall", 32'(StallF), 32'd0); chk("wrap_pcnext", PCNext, 32'd0);

        // Redirect while waiting; late response discarded
        lat = 4; next_data = 32'hDEAD_BEEF; do_reset(32'd0);
        step(1'b0); step(1'b0);
        PCSrcE = 1'b1; PCTargetE = 32'h80;
        @(negedge clk);
        chk("redir_pcnext", PCNext, 32'h80); chk("redir_stall", 32'(StallF), 32'd0);
        step(1'b0); PCSrcE = 1'b0;
        step(1'b0); step(1'b0); @(negedge clk);
        chk("kill_rv", 32'(imem_rvalid), 32'd1); chk("kill_stall", 32'(StallF), 32'd1);
        step(1'b0); @(negedge clk);
        chk("kill_valid", 32'(InstrValidF), 32'd0); chk("kill_req", 32'(imem_req), 32'd1);
        chk("kill_addr", imem_addr, 32'h80);
`ifdef FETCH_PERF_CNT_EN
        chk("kill_cnt", perf_kills, 32'd1);
`endif

        // Skid buffer under decode stall
        lat = 1; next_data = 32'h0050_0093; do_reset(32'd0);
        step(1'b0); step(1'b0); step(1'b0);
        hazard_stall = 1'b1; next_data = 32'h00A0_0113;
        @(negedge clk); chk("skid_a", InstrF, 32'h0050_0093);
        step(1'b0); step(1'b0); @(negedge clk);
        chk("skid_req", 32'(imem_req), 32'd0); chk("skid_hold", InstrF, 32'h0050_0093);
        hazard_stall = 1'b0;
        step(1'b0); @(negedge clk);
        chk("skid_b", InstrF, 32'h00A0_0113); chk("skid_valid", 32'(InstrValidF), 32'd1);
        chk("skid_resume", 32'(imem_req), 32'd1);

        // Reset mid-WAIT, stale response ignored
        lat = 5; next_data = 32'h0BAD_0BAD; do_reset(32'd0);
        step(1'b0); step(1'b0);
        #2 rst = 1'b0; model_reset(); PCF = 32'h100;
        #1;
        chk("mrst_req", 32'(imem_req), 32'd0); chk("mrst_stall", 32'(StallF), 32'd1);
        chk("mrst_pcnext", PCNext, 32'h100); chk("mrst_valid", 32'(InstrValidF), 32'd0);
        chk("mrst_instr", InstrF, 32'h0000_0013);
        step(1'b0); step(1'b0); rst = 1'b1;
        @(negedge clk); chk("mrst_idle", 32'(imem_req), 32'd0);
        step(1'b0); @(negedge clk);
        chk("mrst_req2", 32'(imem_req), 32'd1); chk("mrst_addr", imem_addr, 32'h100);
        repeat (6) step(1'b0);

        // Redirect coincident with response
        lat = 2; next_data = 32'h1111_1111; do_reset(32'd0);
        step(1'b0); step(1'b0); step(1'b0);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        @(negedge clk);
        chk("co_pcnext", PCNext, 32'h200); chk("co_stall", 32'(StallF), 32'd0);
        step(1'b0); PCSrcE = 1'b0; next_data = 32'h0030_0193;
        @(negedge clk);
        chk("co_valid", 32'(InstrValidF), 32'd0); chk("co_addr", imem_addr, 32'h200);
        step(1'b0); step(1'b0); @(negedge clk);
        chk("co_acc", 32'(StallF), 32'd0); chk("co_pc4", PCNext, 32'h204);
        step(1'b0); @(negedge clk); chk("co_instr", InstrF, 32'h0030_0193);

        // Randomized traffic
        do_reset($urandom() & 32'hFFFF_FFFC);
        repeat (4000) step(1'b1);
        rst = 1'b1;
        step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter INSTR_NOP, default 32'h0000_0013: value InstrF SHALL present whenever InstrValidF=0.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 PCF  in  32  current PC from the PC register.
REQ-005 PCNext  out  32  next-PC value driven to the PC register D input.
REQ-006 StallF  out  1  hold request to the PC register.
REQ-007 PCSrcE  in  1  execute-stage redirect; PCTargetE  in  32  redirect target.
REQ-008 hazard_stall  in  1  decode cannot accept an instruction this cycle.
REQ-009 imem_req  out  1; imem_addr  out  32; imem_ready  in  1  request accepted when imem_req and imem_ready are both 1.
REQ-010 imem_rvalid  in  1; imem_rdata  in  32  single response per accepted request, at least 1 cycle later.
REQ-011 InstrF  out  32; InstrValidF  out  1  instruction toward IF/ID, consumed on an edge where InstrValidF=1 and hazard_stall=0.

Function
REQ-012 FSM states SHALL be IDLE, REQ and WAIT, with at most one outstanding memory request.
REQ-013 IDLE SHALL last exactly one cycle after reset release and then go to REQ.
REQ-014 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal PCF, unless skid_valid=1, which blocks the request.
REQ-015 In REQ, an accepted request (imem_ready=1) SHALL move the FSM to WAIT.
REQ-016 In WAIT, imem_rvalid=1 SHALL return the FSM to REQ.
REQ-017 Accept cycle: WAIT, imem_rvalid=1, kill=0 and PCSrcE=0.
REQ-018 In the accept cycle, StallF SHALL be 0 and PCNext SHALL be PCF+4 (mod 2^32, wraps at 32'hFFFF_FFFC).
REQ-019 When PCSrcE=1, in any state, StallF SHALL be 0 and PCNext SHALL be PCTargetE.
REQ-020 In every other cycle, StallF SHALL be 1 and PCNext SHALL be PCF.
REQ-021 On an accept-cycle edge, if InstrValidF=0 or hazard_stall=0, imem_rdata SHALL load InstrF with InstrValidF=1.
REQ-022 Otherwise, on an accept-cycle edge, imem_rdata SHALL load a one-entry skid register and set skid_valid=1.
REQ-023 When InstrValidF=1 and hazard_stall=0, the skid contents SHALL move to InstrF (clearing skid_valid) if skid_valid=1; else InstrValidF SHALL clear, unless REQ-021 loads InstrF on the same edge.
REQ-024 PCSrcE=1 SHALL clear InstrValidF and skid_valid at the next edge.
REQ-025 PCSrcE=1 in WAIT without imem_rvalid, or in REQ with imem_ready=1, SHALL set kill.
REQ-026 A response arriving with kill=1 or PCSrcE=1 SHALL be discarded; kill SHALL clear when that response arrives.
REQ-027 kill=1 SHALL NOT block a new request in REQ.
REQ-028 PCSrcE SHALL take priority over hazard_stall and over all FSM outputs.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, InstrValidF=0, InstrF=INSTR_NOP, skid_valid=0, kill=0, imem_req=0, StallF=1, PCNext=PCF.
REQ-030 Reset asserted with a request outstanding SHALL cause the stale response to be ignored, since imem_rvalid is only sampled in WAIT.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs perf_wait_cycles[31:0] and perf_kills[31:0], both saturating and reset to 0.
REQ-032 perf_wait_cycles SHALL count cycles in WAIT without imem_rvalid; perf_kills SHALL count discarded responses.
REQ-033 Without FETCH_PERF_CNT_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-034 PCF=0, imem_ready=1, rvalid 2 cycles after request, rdata=32'h00500093 -> imem_addr=0; StallF=0 exactly in the response cycle with PCNext=4; next cycle InstrF=32'h00500093 with InstrValidF=1.
REQ-035 PCF=32'hFFFF_FFFC, response returned -> PCNext=32'h0000_0000.
REQ-036 PCSrcE=1, PCTargetE=32'h80 while in WAIT; response arrives 3 cycles later -> PCNext=32'h80 in the redirect cycle; response discarded (InstrValidF stays 0); next imem_addr=32'h80; perf_kills=1 when enabled.
REQ-037 InstrValidF=1 and hazard_stall=1 when a second response 32'h00A00113 arrives -> skid_valid=1 and imem_req=0; hazard_stall drops -> InstrF=32'h00A00113 next edge; requests resume.
REQ-038 rst=0 asserted mid-WAIT, then released -> all outputs at REQ-029 values immediately; one IDLE cycle; next request issued at current PCF.
REQ-039 PCSrcE=1 and imem_rvalid=1 in the same cycle -> response dropped, PCNext=PCTargetE, kill remains 0.
